// File: rtl/enc_sequencer_pkg.sv
// rtl/enc_sequencer_pkg.sv - shared Reed-Solomon encoder defaults, derived sizes and sequencer state type
package enc_sequencer_pkg;

    localparam int EGF_ORDER   = 8;
    localparam int ENC_SYM_NUM = 4;
    localparam int RS_COD_LEN  = 255;
    localparam int RS_MSG_LEN  = 239;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    localparam int MSG_BEATS = ceil_div(RS_MSG_LEN, ENC_SYM_NUM);
    localparam int PAR_BEATS = ceil_div(RS_COD_LEN - RS_MSG_LEN, ENC_SYM_NUM);
    localparam int SYM_CNT_W = $clog2(RS_COD_LEN);
    localparam int DP_CNT_W  = $clog2(ENC_SYM_NUM + 1);

    typedef enum logic [1:0] {
        IDLE,
        MSG,
        PAR
    } enc_seq_state_t;

endpackage

// File: rtl/enc_sequencer_if.sv
// rtl/enc_sequencer_if.sv - upstream handshake and buffer/formatter control bundle of the sequencer
interface enc_sequencer_if #(
    parameter int CNT_W = enc_sequencer_pkg::DP_CNT_W
);
    logic             in_valid;
    logic             in_ready;
    logic             out_ready;
    logic             dp_en;
    logic [CNT_W-1:0] dp_cnt;
    logic             dp_par;
    logic             dp_sof;
    logic             dp_eof;
    logic             busy;
    logic             cw_done;

    modport master (
        input  in_valid, out_ready,
        output in_ready, dp_en, dp_cnt, dp_par, dp_sof, dp_eof, busy, cw_done
    );

    modport slave (
        output in_valid, out_ready,
        input  in_ready, dp_en, dp_cnt, dp_par, dp_sof, dp_eof, busy, cw_done
    );
endinterface

// File: rtl/enc_sequencer_beat_sizer.sv
// rtl/enc_sequencer_beat_sizer.sv - beat size min(S, limit - sym_cnt) and reaches-limit flag
module enc_beat_sizer #(
    parameter int SYM_NUM = 4,
    parameter int CNT_W   = 8,
    parameter int BEAT_W  = 3
) (
    input  logic [CNT_W-1:0]  sym_cnt_i,
    input  logic [CNT_W:0]    limit_i,
    output logic [BEAT_W-1:0] beat_o,
    output logic              reach_o
);
    logic [CNT_W:0] remain;
    logic [CNT_W:0] sum;

    // One extra bit so N = 2^k-1 plus a full beat cannot wrap before the compare.
    always_comb begin
        remain = limit_i - {1'b0, sym_cnt_i};
        if (int'(remain) > SYM_NUM) begin
            beat_o = BEAT_W'(SYM_NUM);
        end else begin
            beat_o = BEAT_W'(remain);
        end
        sum     = {1'b0, sym_cnt_i} + (CNT_W + 1)'(beat_o);
        reach_o = (sum == limit_i);
    end
endmodule

// File: rtl/enc_sequencer.sv
// rtl/enc_sequencer.sv - beat scheduler splitting each codeword into message and parity phases
module enc_sequencer #(
    parameter int EGF_ORDER   = enc_sequencer_pkg::EGF_ORDER,
    parameter int ENC_SYM_NUM = enc_sequencer_pkg::ENC_SYM_NUM,
    parameter int RS_COD_LEN  = enc_sequencer_pkg::RS_COD_LEN,
    parameter int RS_MSG_LEN  = enc_sequencer_pkg::RS_MSG_LEN
) (
    input logic             clk,
    input logic             rst,
    enc_sequencer_if.master bus
);
    import enc_sequencer_pkg::*;

    localparam int SCW = $clog2(RS_COD_LEN);
    localparam int DCW = $clog2(ENC_SYM_NUM + 1);

    if (EGF_ORDER < 1 || ENC_SYM_NUM < 1 || RS_MSG_LEN < 1 || RS_MSG_LEN >= RS_COD_LEN) begin : g_param_check
        $error("enc_sequencer: invalid parameter set");
    end

    enc_seq_state_t state_q, state_d;
    logic [SCW-1:0] sym_cnt_q, sym_cnt_d;
    logic [SCW:0]   limit;
    logic [DCW-1:0] beat;
    logic           reach;
    logic           in_ready;
    logic           msg_fire, par_fire, fire;

    logic           dp_en_q, dp_par_q, dp_sof_q, dp_eof_q, cw_done_q;
    logic [DCW-1:0] dp_cnt_q;

    enc_beat_sizer #(
        .SYM_NUM (ENC_SYM_NUM),
        .CNT_W   (SCW),
        .BEAT_W  (DCW)
    ) u_sizer (
        .sym_cnt_i (sym_cnt_q),
        .limit_i   (limit),
        .beat_o    (beat),
        .reach_o   (reach)
    );

    always_comb begin
        limit    = (state_q == PAR) ? (SCW + 1)'(RS_COD_LEN) : (SCW + 1)'(RS_MSG_LEN);
        in_ready = bus.out_ready & ~rst & (state_q != PAR);
        msg_fire = bus.in_valid & in_ready;
        par_fire = bus.out_ready & (state_q == PAR);
        fire     = msg_fire | par_fire;

        state_d   = state_q;
        sym_cnt_d = sym_cnt_q;
        if (fire) begin
            sym_cnt_d = sym_cnt_q + SCW'(beat);
            if (par_fire && reach) begin
                sym_cnt_d = '0;
                state_d   = IDLE;
            end else if (par_fire || reach) begin
                state_d = PAR;
            end else begin
                state_d = MSG;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sym_cnt_q <= '0;
            dp_en_q   <= 1'b0;
            dp_cnt_q  <= '0;
            dp_par_q  <= 1'b0;
            dp_sof_q  <= 1'b0;
            dp_eof_q  <= 1'b0;
            cw_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sym_cnt_q <= sym_cnt_d;
            dp_en_q   <= fire;
            dp_par_q  <= par_fire;
            dp_sof_q  <= fire && (sym_cnt_q == '0);
            dp_eof_q  <= par_fire && reach;
            cw_done_q <= par_fire && reach;
            if (fire) begin
                dp_cnt_q <= beat;
            end
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.dp_en    = dp_en_q;
    assign bus.dp_cnt   = dp_cnt_q;
    assign bus.dp_par   = dp_par_q;
    assign bus.dp_sof   = dp_sof_q;
    assign bus.dp_eof   = dp_eof_q;
    assign bus.cw_done  = cw_done_q;
    assign bus.busy     = (sym_cnt_q != '0);
endmodule

// File: doc/enc_sequencer.md
# enc_sequencer

- Beat-level scheduler for the Reed-Solomon encoder datapath.
- Accepts message beats from an upstream source over a valid/ready handshake and splits every codeword into a message phase and a parity phase.
- Drives the buffer/formatter control signals:
  - load enable
  - symbols-per-beat count
  - parity-drain select
  - start/end-of-codeword flags
- Sits between the upstream message source and the encoder's buffer/formatter pair, and applies downstream backpressure.

## Interface
Parameters:
- EGF_ORDER, 8, bits per Galois-field symbol.
- ENC_SYM_NUM, 4, symbols per datapath beat (S).
- RS_COD_LEN, 255, codeword length in symbols (N).
- RS_MSG_LEN, 239, message length in symbols (K).

Parameter constraints:
- 1 ≤ RS_MSG_LEN < RS_COD_LEN.
- ENC_SYM_NUM ≥ 1.

Ports (one clock, `clk`; reset `rst` is asynchronous and active-high):
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream message beat available.
- in_ready  out  1  sequencer accepts a message beat this cycle.
- out_ready  in  1  downstream (formatter sink) accepts a beat this cycle.
- dp_en  out  1  registered; datapath performs one beat.
- dp_cnt  out  $clog2(ENC_SYM_NUM+1)  registered; valid symbols in the beat, 1..S.
- dp_par  out  1  registered; beat drains parity (0 = message beat).
- dp_sof  out  1  registered; first beat of a codeword.
- dp_eof  out  1  registered; last beat of a codeword.
- busy  out  1  a codeword is in progress (sym_cnt ≠ 0).
- cw_done  out  1  registered one-cycle pulse, coincident with dp_eof.

## Operation
- States:
  - IDLE: sym_cnt = 0.
  - MSG: 0 < sym_cnt < K.
  - PAR: K ≤ sym_cnt < N.
- sym_cnt width: $clog2(RS_COD_LEN). It counts symbols issued in the current codeword.
- in_ready = out_ready & (state ∈ {IDLE, MSG}). It is combinational from state and out_ready, and independent of in_valid.
- Fire rules:
  - Message fire = in_valid & in_ready.
  - Parity fire = out_ready & (state == PAR). No input is consumed.
- Beat size on fire:
  - Message: min(S, K − sym_cnt).
  - Parity: min(S, N − sym_cnt).
  - A message beat never carries parity symbols; a partial last message beat is emitted short.
- On fire, sym_cnt += beat size. If the result equals N, sym_cnt wraps to 0 and the state goes to IDLE.
- Transitions:
  - IDLE→MSG on the first message fire, or IDLE→PAR if K ≤ S.
  - MSG→PAR when sym_cnt reaches K.
  - PAR→IDLE when sym_cnt reaches N.
- dp_sof is set on a fire with sym_cnt = 0. dp_eof and cw_done are set on a fire that reaches N.
- No fire: dp_en = 0 and all dp_* flags = 0; dp_cnt holds its last value (don't-care when dp_en = 0).
- Arithmetic: compare sym_cnt+beat against N in a width of $clog2(RS_COD_LEN)+1 bits to avoid overflow at N = 2^k−1.

## Timing
- Reset values: dp_en = dp_par = dp_sof = dp_eof = cw_done = 0, dp_cnt = 0, busy = 0, state IDLE, sym_cnt = 0.
- in_ready is 0 while rst is asserted.
- Latency: the dp_* outputs appear 1 cycle after the fire cycle.
- Back-to-back codewords: the first beat of codeword n+1 may fire in the cycle after the eof fire of codeword n, with no bubble.
- out_ready low: no fire, state frozen, dp_en = 0 the next cycle. in_valid may stay high.
- Parity phase: in_ready = 0 for all ceil((N−K)/S) parity beats, regardless of in_valid.
- Reset mid-codeword: all state clears asynchronously and the partial codeword is discarded. Once rst deasserts, the next accepted beat carries dp_sof.
- K mod S = 0: every message beat is full. (N−K) mod S = 0: every parity beat is full.

## Structure
- Shared encoder package/header holds:
  - EGF_ORDER, ENC_SYM_NUM, RS_COD_LEN, RS_MSG_LEN
  - derived localparams: message beats, parity beats, width of sym_cnt and dp_cnt
  - state enum enc_seq_state_t {IDLE, MSG, PAR}
- One sub-module: enc_beat_sizer. It is combinational and computes min(S, limit − sym_cnt) plus a reaches-limit flag; it is instantiated once and muxed between K and N by state.

## Test plan
- Defaults (S=4, K=239, N=255), in_valid and out_ready held high for one codeword:
  - 60 message beats: dp_cnt = 4 ×59, then 3.
  - Then 4 parity beats: dp_cnt = 4, dp_par = 1.
  - dp_sof on beat 1, dp_eof/cw_done on beat 64, in_ready low for 4 cycles.
- Two codewords back to back: the second dp_sof appears exactly 1 cycle after the first dp_eof; 128 dp_en cycles total.
- out_ready toggled 0/1 every cycle during the parity phase: each parity beat is stretched to 2 cycles, with no lost or duplicated beat; symbol sum = 255.
- rst pulsed at sym_cnt = 100: outputs read 0 immediately and busy = 0. After release, the first accepted beat has dp_sof = 1, and 64 beats follow.
- Parameters S=4, K=8, N=16:
  - Beats are 2 message + 2 parity, all dp_cnt = 4.
  - Then with S=5, K=8, N=16: message dp_cnt 5, 3; parity dp_cnt 5, 3.
- in_valid low for 10 cycles mid-message: state and sym_cnt hold, dp_en = 0, and the count resumes correctly afterwards.
